seq_udiv: RTL and testbench



---
 rtl/seq_udiv.sv | 99 +++++++++
 tb/tb_seq_udiv.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seq_udiv.sv
// Sequential unsigned restoring divider: one quotient bit per clock behind a
// start/busy/done handshake, giving fixed n+1 cycle latency from start to done.
module seq_udiv #(
  parameter int n = 16,
  parameter int m = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [m-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] q,
  output logic [m-1:0] r,
  output logic         dz
);

  localparam int cw = $clog2(n + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state, state_n;
  logic [cw-1:0]  cnt;
  logic [n-1:0]   quo;
  logic [m-1:0]   rem;
  logic [m-1:0]   div;

  logic           load;
  logic [m:0]     shifted;
  logic           borrow;
  logic [m-1:0]   trial;
  logic [m-1:0]   rem_step;
  logic [n-1:0]   quo_step;

  // The remainder stays below the divisor between steps, so it fits in m bits;
  // the m+1-bit partial remainder only exists transiently as 'shifted'.
  always_comb begin
    shifted  = {rem, quo[n-1]};
    borrow   = shifted < {1'b0, div};
    trial    = shifted[m-1:0] - div;
    rem_step = borrow ? shifted[m-1:0] : trial;
    quo_step = {quo[n-2:0], ~borrow};
  end

  assign load = start && (state != RUN);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous, so it lives inside the edge.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (cnt == cw'(1)) state_n = DONE;
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      quo <= '0;
      rem <= '0;
      div <= '0;
      q   <= '0;
      r   <= '0;
      dz  <= 1'b0;
    end else if (load) begin
      quo <= a;
      div <= b;
      rem <= '0;
      cnt <= cw'(n);
    end else if (state == RUN) begin
      quo <= quo_step;
      rem <= rem_step;
      cnt <= cnt - cw'(1);
      if (cnt == cw'(1)) begin
        // A zero divisor never borrows; results are forced to the defined values.
        q  <= (div == '0) ? '1 : quo_step;
        r  <= (div == '0) ? '0 : rem_step;
        dz <= (div == '0);
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_udiv.sv
// Directed testbench for seq_udiv (n=m=16): reset, arithmetic corners, divide
// by zero, start-while-busy, back-to-back, mid-run reset and a short random sweep.
module tb_seq_udiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        busy, done, dz;
  logic [15:0] q, r;

  int tests = 0;
  int fails = 0;

  seq_udiv #(.n(16), .m(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a request in the cycle before the next rising edge (edge T).
  task automatic launch(input logic [15:0] av, input logic [15:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count cycles after the accepting edge until done; bounded at 40.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (done) break;
    end
  endtask

  task automatic op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                    input logic [15:0] eq, input logic [15:0] er, input logic edz);
    int lat, bcnt;
    launch(av, bv);
    wait_done(lat, bcnt);
    check({tag, " latency"}, lat, 17);
    check({tag, " busy cycles"}, bcnt, 16);
    check({tag, " q"}, q, eq);
    check({tag, " r"}, r, er);
    check({tag, " dz"}, dz, edz);
  endtask

  initial begin
    int lat, bcnt, seen;
    logic [15:0] ra, rb;

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset q", q, 0);
    check("reset r", r, 0);
    check("reset dz", dz, 0);

    op("1000/7", 16'd1000, 16'd7, 16'd142, 16'd6, 1'b0);
    @(negedge clk);
    check("done is one cycle", done, 0);
    check("q holds after done", q, 142);
    check("r holds after done", r, 6);

    op("ffff/1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);
    op("3/10", 16'd3, 16'd10, 16'd0, 16'd3, 1'b0);
    op("ffff/ffff", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0);
    op("5/0", 16'd5, 16'd0, 16'hFFFF, 16'd0, 1'b1);
    op("9/3", 16'd9, 16'd3, 16'd3, 16'd0, 1'b0);

    // Start re-asserted three cycles into RUN must not disturb the operation.
    launch(16'd100, 16'd9);
    repeat (3) @(negedge clk);
    a = 16'd1;
    b = 16'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bcnt);
    check("mid-run start latency", lat, 14);
    check("100/9 q", q, 11);
    check("100/9 r", r, 1);

    // Back-to-back: start held during the done cycle.
    a = 16'd50;
    b = 16'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("b2b busy after accept", busy, 1);
    check("b2b done after accept", done, 0);
    wait_done(lat, bcnt);
    check("b2b latency", lat, 16);
    check("50/7 q", q, 7);
    check("50/7 r", r, 1);

    // Reset five cycles into RUN, with a simultaneous start that must be ignored.
    launch(16'd1000, 16'd7);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    a = 16'd3;
    b = 16'd1;
    @(posedge clk);
    #1 begin
      rst = 1'b0;
      start = 1'b0;
    end
    @(negedge clk);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort q", q, 0);
    check("abort r", r, 0);
    check("abort dz", dz, 0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("no activity after abort", seen, 0);
    op("post-abort 1000/7", 16'd1000, 16'd7, 16'd142, 16'd6, 1'b0);

    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      rb = (i % 3 == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom_range(1, 65535));
      op("random", ra, rb, ra / rb, ra % rb, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
